// File: rtl/seq_mux_if.sv
// Purpose : command + output-stream bundle for the seq_mux index sequencer.
// Latency : n/a (signal container only).
// Backpressure : out_ready from the consumer stalls the sequencer's output register.
//
// Signals
//   start/base/stride/count : sequence request, sampled on an accepted start
//   busy/done               : sequencer status (done is a one-cycle pulse)
//   out_data/out_idx/out_last/out_valid/out_ready : registered output stream
//   oor                     : only with SEQ_MUX_OOR_ZERO_EN, flags an out-of-range first word
// Modports: master = sequencer side, slave = requester/consumer side.
interface seq_mux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 16
);
  localparam int SEL_W = $clog2(N);

  logic               start;
  logic [SEL_W-1:0]   base;
  logic [SEL_W-1:0]   stride;
  logic [SEL_W:0]     count;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
`ifdef SEQ_MUX_OOR_ZERO_EN
  logic               oor;

  modport master (
    input  start, base, stride, count, out_ready,
    output busy, done, out_data, out_idx, out_valid, out_last, oor
  );
  modport slave (
    output start, base, stride, count, out_ready,
    input  busy, done, out_data, out_idx, out_valid, out_last, oor
  );
`else
  modport master (
    input  start, base, stride, count, out_ready,
    output busy, done, out_data, out_idx, out_valid, out_last
  );
  modport slave (
    output start, base, stride, count, out_ready,
    input  busy, done, out_data, out_idx, out_valid, out_last
  );
`endif
endinterface

// File: rtl/seq_mux.sv
// Purpose : N-to-1 word selector that walks `count` indices from `base` by `stride` (mod N).
// Latency : first word valid 1 cycle after an accepted start, then one word per transfer.
// Backpressure : out_ready low holds out_data/out_idx/out_last/out_valid; in_flat sampled only on load edges.
//
// Ports
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_flat    : N words, word i at [i*WIDTH +: WIDTH]
//   io         : seq_mux_if.master (start/base/stride/count, busy/done, output stream)
// Build option: SEQ_MUX_OOR_ZERO_EN -- a base >= N emits a zero word at index `base` with
// io.oor set, and the walk continues from base-N. Without it, base >= N is folded to base-N.
module seq_mux #(
  parameter  int WIDTH = 8,
  parameter  int N     = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_flat,
  seq_mux_if.master          io
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);
  localparam logic [SEL_W:0] ONE   = (SEL_W+1)'(1);
  localparam logic [SEL_W:0] TWO   = (SEL_W+1)'(2);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   stride_q, stride_d;
  logic [SEL_W:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
`ifdef SEQ_MUX_OOR_ZERO_EN
  logic               oor_q, oor_d;
`endif

  logic [SEL_W:0]     base_ext, stride_ext, sum;
  logic               base_oor;
  logic [SEL_W-1:0]   base_red, stride_red, next_idx, sel;
  logic [WIDTH-1:0]   sel_word;

  // Index arithmetic. idx_q always holds an in-range index. The stride is also
  // folded below N when latched so a single conditional subtract after the add
  // keeps the next index in range even for non-power-of-2 N.
  always_comb begin
    base_ext   = {1'b0, io.base};
    stride_ext = {1'b0, io.stride};
    base_oor   = (base_ext >= N_EXT);
    base_red   = base_oor ? SEL_W'(base_ext - N_EXT) : io.base;
    stride_red = (stride_ext >= N_EXT) ? SEL_W'(stride_ext - N_EXT) : io.stride;
    sum        = {1'b0, idx_q} + {1'b0, stride_q};
    next_idx   = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : sum[SEL_W-1:0];
    // One shared word mux: IDLE loads the first word, RUN loads the successor.
    sel        = (state_q == IDLE) ? base_red : next_idx;
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_word = in_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stride_d    = stride_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef SEQ_MUX_OOR_ZERO_EN
    oor_d       = oor_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          if (io.count == '0) begin
            // Empty request completes immediately without touching the stream.
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            idx_d       = base_red;
            stride_d    = stride_red;
            rem_d       = io.count;
            out_data_d  = sel_word;
            out_idx_d   = base_red;
            out_valid_d = 1'b1;
            out_last_d  = (io.count == ONE);
`ifdef SEQ_MUX_OOR_ZERO_EN
            // Out-of-range first word: report the raw index with zero data;
            // idx_q already holds base-N so the walk continues from there.
            if (base_oor) begin
              out_data_d = '0;
              out_idx_d  = io.base;
            end
            oor_d = base_oor;
`endif
          end
        end
      end
      RUN: begin
        if (out_valid_q && io.out_ready) begin
          if (rem_q > ONE) begin
            idx_d      = next_idx;
            out_data_d = sel_word;
            out_idx_d  = next_idx;
            out_last_d = (rem_q == TWO);
            rem_d      = rem_q - ONE;
`ifdef SEQ_MUX_OOR_ZERO_EN
            oor_d      = 1'b0;
`endif
          end else begin
            state_d     = IDLE;
            rem_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
`ifdef SEQ_MUX_OOR_ZERO_EN
            oor_d       = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_MUX_OOR_ZERO_EN
      oor_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stride_q    <= stride_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef SEQ_MUX_OOR_ZERO_EN
      oor_q       <= oor_d;
`endif
    end
  end

  assign io.busy      = (state_q == RUN);
  assign io.done      = done_q;
  assign io.out_data  = out_data_q;
  assign io.out_idx   = out_idx_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
`ifdef SEQ_MUX_OOR_ZERO_EN
  assign io.oor       = oor_q;
`endif

endmodule
